// File: rtl/exu_oitf_ooo.sv
// ---------------------------------------------------------------------------
// exu_oitf_ooo
// Outstanding-instruction tracking FIFO for the EXU long-pipe path.
//
// Behaviour
//   Dispatch allocates one entry per long-pipe instruction and receives its
//   itag. Completions (itag + data) may arrive in any order. Entries retire
//   strictly in program order to the write-back arbiter. Dispatch also gets
//   RAW/WAW hazard matches against every entry that is still valid.
//
// Optional feature
//   Define OITF_FLUSH_EN to add the flush_req input. A flush clears every
//   entry and both pointers. Without the macro, entries leave only by
//   retiring.
//
// Ports
//   clk, rst_n                 clock; synchronous active-low reset
//   disp_*                     allocation handshake, itag out (dis_ptr),
//                              operand info used for hazard checks
//   oitfrd_match_disprs1/2/rd  combinational hazard matches
//   cmpl_valid/itag/data       completion strobe (no back-pressure)
//   cmpl_err                   registered pulse for a dropped completion
//   ret_*                      in-order retire handshake and head payload
//   oitf_empty/full/count      occupancy status
//   flush_req                  (OITF_FLUSH_EN only) clear all entries
// ---------------------------------------------------------------------------
module exu_oitf_ooo #(
  parameter int DEPTH   = 4,
  parameter int PTR_W   = 2,
  parameter int RFIDX_W = 5,
  parameter int XLEN    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef OITF_FLUSH_EN
  input  logic               flush_req,
`endif
  input  logic               disp_ena,
  output logic               disp_ready,
  output logic [PTR_W-1:0]   dis_ptr,
  input  logic               disp_i_rs1en,
  input  logic               disp_i_rs2en,
  input  logic               disp_i_rdwen,
  input  logic [RFIDX_W-1:0] disp_i_rs1idx,
  input  logic [RFIDX_W-1:0] disp_i_rs2idx,
  input  logic [RFIDX_W-1:0] disp_i_rdidx,
  output logic               oitfrd_match_disprs1,
  output logic               oitfrd_match_disprs2,
  output logic               oitfrd_match_disprd,
  input  logic               cmpl_valid,
  input  logic [PTR_W-1:0]   cmpl_itag,
  input  logic [XLEN-1:0]    cmpl_data,
  output logic               cmpl_err,
  output logic               ret_valid,
  input  logic               ret_ready,
  output logic [PTR_W-1:0]   ret_ptr,
  output logic               ret_rdwen,
  output logic [RFIDX_W-1:0] ret_rdidx,
  output logic [XLEN-1:0]    ret_data,
  output logic               oitf_empty,
  output logic               oitf_full,
  output logic [PTR_W:0]     oitf_count
);

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [DEPTH-1:0]   r_vld;
  logic [DEPTH-1:0]   r_done;
  logic [DEPTH-1:0]   r_rdwen;
  logic [RFIDX_W-1:0] r_rdidx [DEPTH];
  logic [XLEN-1:0]    r_data  [DEPTH];
  // The top bit of each pointer is a wrap bit. It separates full from empty
  // when the two indices are equal.
  logic [PTR_W:0]     r_alcPtr;
  logic [PTR_W:0]     r_retPtr;
  logic               r_cmplErr;

  logic [PTR_W-1:0]   w_alcIdx;
  logic [PTR_W-1:0]   w_retIdx;
  logic               w_flush;
  logic               w_full;
  logic               w_alloc;
  logic               w_retire;
  logic               w_cmplOk;
  logic               w_hitRs1;
  logic               w_hitRs2;
  logic               w_hitRd;

`ifdef OITF_FLUSH_EN
  assign w_flush = flush_req;
`else
  assign w_flush = 1'b0;
`endif

  assign w_alcIdx = r_alcPtr[PTR_W-1:0];
  assign w_retIdx = r_retPtr[PTR_W-1:0];
  assign w_full   = (w_alcIdx == w_retIdx) && (r_alcPtr[PTR_W] != r_retPtr[PTR_W]);

  // Full blocks allocation even when a retire happens in the same cycle.
  // This keeps disp_ready a function of registered state only.
  assign disp_ready = !w_full && !w_flush;
  assign w_alloc    = disp_ena && disp_ready;
  assign dis_ptr    = w_alcIdx;

  assign ret_valid = r_vld[w_retIdx] && r_done[w_retIdx] && !w_flush;
  assign w_retire  = ret_valid && ret_ready;
  assign ret_ptr   = w_retIdx;
  assign ret_rdwen = r_rdwen[w_retIdx];
  assign ret_rdidx = r_rdidx[w_retIdx];
  assign ret_data  = r_data[w_retIdx];

  // A completion is accepted only for an entry that is in flight and not yet
  // done. The entry being allocated is still invalid this cycle, so a
  // completion aimed at it is dropped.
  assign w_cmplOk = cmpl_valid && r_vld[cmpl_itag] && !r_done[cmpl_itag];
  assign cmpl_err = r_cmplErr;

  assign oitf_empty = (r_alcPtr == r_retPtr);
  assign oitf_full  = w_full;
  assign oitf_count = r_alcPtr - r_retPtr;

  // Control state: valid/done bits, the two pointers and the error pulse.
  // Retire and completion never touch the same entry, because retire needs
  // done=1 and completion needs done=0. Allocation never aliases the head
  // because allocation is blocked when the FIFO is full.
  always_ff @(posedge clk) begin
    if (!rst_n || w_flush) begin
      r_vld     <= '0;
      r_done    <= '0;
      r_alcPtr  <= '0;
      r_retPtr  <= '0;
      r_cmplErr <= 1'b0;
    end else begin
      r_cmplErr <= cmpl_valid && !w_cmplOk;
      if (w_retire) begin
        r_vld[w_retIdx]  <= 1'b0;
        r_done[w_retIdx] <= 1'b0;
        r_retPtr         <= r_retPtr + PTR_ONE;
      end
      if (w_cmplOk) begin
        r_done[cmpl_itag] <= 1'b1;
      end
      if (w_alloc) begin
        r_vld[w_alcIdx]  <= 1'b1;
        r_done[w_alcIdx] <= 1'b0;
        r_alcPtr         <= r_alcPtr + PTR_ONE;
      end
    end
  end

  // Payload storage has no reset. It is only observed through entries whose
  // valid bit is set, and that bit is always rewritten before use.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_rdwen[w_alcIdx] <= disp_i_rdwen;
      r_rdidx[w_alcIdx] <= disp_i_rdidx;
    end
    if (w_cmplOk && !w_flush) begin
      r_data[cmpl_itag] <= cmpl_data;
    end
  end

  // Hazard search over every valid entry that writes a register. Done but
  // unretired entries still match, because their result has not reached the
  // register file yet.
  always_comb begin
    w_hitRs1 = 1'b0;
    w_hitRs2 = 1'b0;
    w_hitRd  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && r_rdwen[i]) begin
        if (r_rdidx[i] == disp_i_rs1idx) w_hitRs1 = 1'b1;
        if (r_rdidx[i] == disp_i_rs2idx) w_hitRs2 = 1'b1;
        if (r_rdidx[i] == disp_i_rdidx)  w_hitRd  = 1'b1;
      end
    end
  end

  // x0 is hardwired, so an operand of index 0 never creates a hazard.
  assign oitfrd_match_disprs1 = disp_i_rs1en && (disp_i_rs1idx != '0) && w_hitRs1;
  assign oitfrd_match_disprs2 = disp_i_rs2en && (disp_i_rs2idx != '0) && w_hitRs2;
  assign oitfrd_match_disprd  = disp_i_rdwen && (disp_i_rdidx  != '0) && w_hitRd;

endmodule
